updown_counter_param: RTL and testbench

//   Parametrised synchronous up/down counter with programmable limit, wrap or

---
 rtl/updown_counter_param.sv | 105 ++++++++++
 tb/tb_updown_counter_param.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_param.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_param
// Description : Parametrised synchronous up/down counter over the range
//               [0, lim]. Supports wrap or saturate at the boundary,
//               synchronous clear/load, a combinational terminal-count flag
//               and a sticky boundary-event (overflow) flag.
//
//   Ports
//     c        in   1      clock, rising edge
//     r        in   1      asynchronous reset, active-low
//     en       in   1      count enable
//     m        in   1      direction: 1 = down, 0 = up
//     sat      in   1      1 = saturate at boundary, 0 = wrap
//     lim      in   WIDTH  upper bound of the count range
//     clr      in   1      synchronous restart to 0 (up) or lim (down)
//     ld       in   1      synchronous load of d (clamped to lim)
//     d        in   WIDTH  load value
//     clr_ovf  in   1      clears the sticky ovf flag
//     o        out  WIDTH  registered count value
//     tc       out  1      terminal count (combinational)
//     ovf      out  1      sticky boundary-event flag (registered)
//
// Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_param #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             c,
    input  logic             r,
    input  logic             en,
    input  logic             m,
    input  logic             sat,
    input  logic [WIDTH-1:0] lim,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] o,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_ovf_nxt;
    logic             w_up_bnd;
    logic             w_dn_bnd;
    logic             w_at_bnd;

    // Up boundary uses >= so that lowering lim below the current count makes
    // the next up-count a boundary event instead of running past lim.
    assign w_up_bnd = (r_cnt >= lim);
    assign w_dn_bnd = (r_cnt == c_zero);
    assign w_at_bnd = m ? w_dn_bnd : w_up_bnd;

    always_comb begin
        w_cnt_nxt = r_cnt;
        // A boundary event below overrides this clear, so set wins over
        // clr_ovf in the same cycle.
        w_ovf_nxt = r_ovf & ~clr_ovf;
        if (clr) begin
            w_cnt_nxt = m ? lim : c_zero;
            w_ovf_nxt = 1'b0;
        end else if (ld) begin
            w_cnt_nxt = (d > lim) ? lim : d;
        end else if (en) begin
            if (w_at_bnd) begin
                w_ovf_nxt = 1'b1;
                if (m) begin
                    w_cnt_nxt = sat ? c_zero : lim;
                end else begin
                    w_cnt_nxt = sat ? lim : c_zero;
                end
            end else if (m) begin
                // Also covers a count sitting above lim after lim was lowered.
                w_cnt_nxt = r_cnt - c_one;
            end else begin
                w_cnt_nxt = r_cnt + c_one;
            end
        end
    end

    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            r_cnt <= RST_VAL;
            r_ovf <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    assign o   = r_cnt;
    assign ovf = r_ovf;
    // Gated by r so terminal count stays low throughout reset.
    assign tc  = r & en & w_at_bnd;

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_counter_param
// Description : Scoreboard testbench for updown_counter_param (WIDTH=4,
//               RST_VAL=0). Directed stimulus pushes hand-computed expected
//               o/ovf/tc into queues; an independent monitor pops and
//               compares after each rising edge or asynchronous reset event.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_counter_param;

    logic       c;
    logic       r;
    logic       en;
    logic       m;
    logic       sat;
    logic [3:0] lim;
    logic       clr;
    logic       ld;
    logic [3:0] d;
    logic       clr_ovf;
    logic [3:0] o;
    logic       tc;
    logic       ovf;

    int total;
    int bad;

    logic [3:0] q_o[$];
    logic       q_ovf[$];
    logic       q_tc[$];
    string      q_nm[$];

    event e_async;

    updown_counter_param #(
        .WIDTH  (4),
        .RST_VAL(4'd0)
    ) u_dut (
        .c      (c),
        .r      (r),
        .en     (en),
        .m      (m),
        .sat    (sat),
        .lim    (lim),
        .clr    (clr),
        .ld     (ld),
        .d      (d),
        .clr_ovf(clr_ovf),
        .o      (o),
        .tc     (tc),
        .ovf    (ovf)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    // Monitor: after each rising edge (or an async-reset notification) pop
    // one expected entry and compare it with the DUT outputs.
    initial begin
        forever begin
            @(posedge c or e_async);
            #1;
            if (q_o.size() > 0) begin
                logic [3:0] eo;
                logic       eovf;
                logic       etc;
                string      nm;
                eo   = q_o.pop_front();
                eovf = q_ovf.pop_front();
                etc  = q_tc.pop_front();
                nm   = q_nm.pop_front();
                total++;
                if (o !== eo) begin
                    bad++;
                    $display("FAIL %s o: got %0d expected %0d", nm, o, eo);
                end
                total++;
                if (ovf !== eovf) begin
                    bad++;
                    $display("FAIL %s ovf: got %0b expected %0b", nm, ovf, eovf);
                end
                total++;
                if (tc !== etc) begin
                    bad++;
                    $display("FAIL %s tc: got %0b expected %0b", nm, tc, etc);
                end
            end
        end
    end

    // One clock step: drive inputs on the falling edge, record what the DUT
    // must show just after the following rising edge (inputs still held).
    task automatic step(input logic s_en, input logic s_m, input logic s_sat,
                        input logic s_clr, input logic s_ld, input logic s_co,
                        input logic [3:0] s_lim, input logic [3:0] s_d,
                        input logic [3:0] eo, input logic eovf, input logic etc,
                        input string nm);
        @(negedge c);
        r       = 1'b1;
        en      = s_en;
        m       = s_m;
        sat     = s_sat;
        clr     = s_clr;
        ld      = s_ld;
        clr_ovf = s_co;
        lim     = s_lim;
        d       = s_d;
        q_o.push_back(eo);
        q_ovf.push_back(eovf);
        q_tc.push_back(etc);
        q_nm.push_back(nm);
    endtask

    // Assert reset between edges and check outputs without waiting for c.
    task automatic async_reset(input string nm);
        @(negedge c);
        #2;
        r = 1'b0;
        q_o.push_back(4'd0);
        q_ovf.push_back(1'b0);
        q_tc.push_back(1'b0);
        q_nm.push_back(nm);
        ->e_async;
        #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        r       = 1'b0;
        en      = 1'b1;
        m       = 1'b1;
        sat     = 1'b0;
        clr     = 1'b0;
        ld      = 1'b0;
        clr_ovf = 1'b0;
        lim     = 4'd9;
        d       = 4'd0;

        // Reset state: o=0 at 0, down, en=1 would be terminal, but tc is gated.
        async_reset("reset_init");

        // 1. count to 6, async reset, resume from 0
        for (int k = 1; k <= 6; k++)
            step(1, 0, 0, 0, 0, 0, 4'd9, 4'd0, 4'(k), 0, 0, "t1_count");
        async_reset("t1_async_rst");
        step(1, 0, 0, 0, 0, 0, 4'd9, 4'd0, 4'd1, 0, 0, "t1_resume");

        // 2. wrap up-count at lim=9
        step(0, 0, 0, 1, 0, 0, 4'd9, 4'd0, 4'd0, 0, 0, "t2_clr");
        for (int k = 1; k <= 9; k++)
            step(1, 0, 0, 0, 0, 0, 4'd9, 4'd0, 4'(k), 0, (k == 9), "t2_up");
        step(1, 0, 0, 0, 0, 0, 4'd9, 4'd0, 4'd0, 1, 0, "t2_wrap");
        step(1, 0, 0, 0, 0, 0, 4'd9, 4'd0, 4'd1, 1, 0, "t2_after_wrap");

        // 3. clr in down mode loads lim, count down, saturate at 0
        step(0, 1, 1, 1, 0, 0, 4'd9, 4'd0, 4'd9, 0, 0, "t3_clr_down");
        for (int k = 8; k >= 0; k--)
            step(1, 1, 1, 0, 0, 0, 4'd9, 4'd0, 4'(k), 0, (k == 0), "t3_down");
        for (int k = 0; k < 3; k++)
            step(1, 1, 1, 0, 0, 0, 4'd9, 4'd0, 4'd0, 1, 1, "t3_sat_hold");

        // 4. load clamp, load over count, clr over load
        step(0, 0, 0, 0, 1, 0, 4'd9, 4'd12, 4'd9, 1, 0, "t4_ld_clamp");
        step(1, 0, 0, 0, 1, 0, 4'd9, 4'd3, 4'd3, 1, 0, "t4_ld_over_en");
        step(1, 0, 0, 1, 1, 0, 4'd9, 4'd5, 4'd0, 0, 0, "t4_clr_over_ld");

        // 5. boundary set beats clr_ovf, then clr_ovf alone clears
        step(0, 0, 0, 0, 1, 0, 4'd9, 4'd9, 4'd9, 0, 0, "t5_ld9");
        step(1, 0, 0, 0, 0, 1, 4'd9, 4'd0, 4'd0, 1, 0, "t5_set_wins");
        step(0, 0, 0, 0, 0, 1, 4'd9, 4'd0, 4'd0, 0, 0, "t5_clr_ovf");

        // 6. lim=0 with direction toggling, then full 4-bit range
        step(1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 1, 1, "t6_lim0_up");
        step(1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 1, 1, "t6_lim0_up");
        step(1, 1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 1, 1, "t6_lim0_dn");
        step(1, 1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 1, 1, "t6_lim0_dn");
        step(1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 1, 1, "t6_lim0_up2");
        for (int k = 1; k <= 15; k++)
            step(1, 0, 0, 0, 0, 0, 4'd15, 4'd0, 4'(k), 1, (k == 15), "t6_full");
        step(1, 0, 0, 0, 0, 0, 4'd15, 4'd0, 4'd0, 1, 0, "t6_full_wrap");

        // 7. lim lowered below count: down still decrements, up saturates
        step(0, 0, 0, 1, 0, 0, 4'd15, 4'd0, 4'd0, 0, 0, "t7_clr");
        step(0, 0, 0, 0, 1, 0, 4'd15, 4'd12, 4'd12, 0, 0, "t7_ld12");
        step(1, 1, 1, 0, 0, 0, 4'd5, 4'd0, 4'd11, 0, 0, "t7_dn_above_lim");
        step(1, 0, 1, 0, 0, 0, 4'd5, 4'd0, 4'd5, 1, 1, "t7_up_sat");
        step(1, 0, 1, 0, 0, 0, 4'd5, 4'd0, 4'd5, 1, 1, "t7_up_sat_hold");

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 20 && q_o.size() > 0; k++)
            @(posedge c);
        #2;
        if (q_o.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending entries expected 0", q_o.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
